// File: rtl/cmd_decoder_mc.sv
// Command decoder for the ultrasonic TX/RX/DAC datapath.
// Each word runs three cycles (capture, decode/check, apply); the results are registered strobes and per-channel state.
module cmd_decoder_mc #(
  parameter int DATA_WIDTH = 16,
  parameter int CH_W       = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [DATA_WIDTH-1:0]      cmd_data,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  output logic [2**CH_W-1:0]         ch_en,
  output logic                       dac_wr,
  output logic [CH_W-1:0]            dac_ch,
  output logic [DATA_WIDTH-8-CH_W:0] dac_level,
  output logic                       sat,
  output logic                       tx_start,
  output logic                       rx_start,
  output logic [CH_W-1:0]            cmd_ch,
  output logic                       err,
  output logic [2:0]                 err_code
);

  localparam int NUM_CH = 2**CH_W;
  localparam int AMT_W  = DATA_WIDTH - 7 - CH_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DEC   = 2'd1,
    ST_APPLY = 2'd2
  } state_t;

  state_t                 state_q;
  logic [DATA_WIDTH-1:0]  word_q;
  logic [NUM_CH-1:0]      ch_en_q;
  logic [AMT_W-1:0]       level_q [NUM_CH];

  logic [2:0]             pend_err_q;
  logic                   pend_on_q, pend_off_q, pend_dac_q, pend_sat_q;
  logic                   pend_tx_q, pend_rx_q;
  logic [CH_W-1:0]        pend_ch_q;
  logic [AMT_W-1:0]       pend_lvl_q;

  logic                   w_on, w_off, w_inc, w_dec, w_rcv, w_snd, w_vld;
  logic [CH_W-1:0]        ch_d;
  logic [AMT_W-1:0]       amt_d, cur_d, lvl_d;
  logic [AMT_W:0]         sum_d, diff_d;
  logic                   en_after_d, sat_d;
  logic [2:0]             err_d;

  assign cmd_ready = (state_q == ST_IDLE);
  assign ch_en     = ch_en_q;

  // Field decode, error priority and saturating level arithmetic for the captured word.
  always_comb begin
    w_on   = word_q[0];
    w_off  = word_q[1];
    w_inc  = word_q[2];
    w_dec  = word_q[3];
    w_rcv  = word_q[4];
    w_snd  = word_q[5];
    w_vld  = word_q[6];
    ch_d   = word_q[6+CH_W:7];
    amt_d  = word_q[DATA_WIDTH-1:7+CH_W];
    cur_d  = level_q[ch_d];
    sum_d  = {1'b0, cur_d} + {1'b0, amt_d};
    diff_d = {1'b0, cur_d} - {1'b0, amt_d};
    lvl_d  = cur_d;
    sat_d  = 1'b0;
    err_d  = 3'd0;

    // The enable seen by send/receive is the one after this word's own on/off.
    if (w_on) begin
      en_after_d = 1'b1;
    end else if (w_off) begin
      en_after_d = 1'b0;
    end else begin
      en_after_d = ch_en_q[ch_d];
    end

    if (w_on && w_off) begin
      err_d = 3'd1;
    end else if (w_inc && w_dec) begin
      err_d = 3'd2;
    end else if (w_snd && w_rcv) begin
      err_d = 3'd3;
    end else if (!w_vld) begin
      err_d = 3'd4;
    end else if ((w_snd || w_rcv) && !en_after_d) begin
      err_d = 3'd5;
    end else begin
      err_d = 3'd0;
    end

    if (w_inc) begin
      lvl_d = sum_d[AMT_W] ? {AMT_W{1'b1}} : sum_d[AMT_W-1:0];
      sat_d = sum_d[AMT_W];
    end else if (w_dec) begin
      lvl_d = diff_d[AMT_W] ? {AMT_W{1'b0}} : diff_d[AMT_W-1:0];
      sat_d = diff_d[AMT_W];
    end else begin
      lvl_d = cur_d;
      sat_d = 1'b0;
    end
  end

  // Capture / decode / apply sequencer with registered outputs and one-cycle strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_q     <= '0;
      ch_en_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) level_q[i] <= '0;
      pend_err_q <= 3'd0;
      pend_on_q  <= 1'b0;
      pend_off_q <= 1'b0;
      pend_dac_q <= 1'b0;
      pend_sat_q <= 1'b0;
      pend_tx_q  <= 1'b0;
      pend_rx_q  <= 1'b0;
      pend_ch_q  <= '0;
      pend_lvl_q <= '0;
      dac_wr     <= 1'b0;
      dac_ch     <= '0;
      dac_level  <= '0;
      sat        <= 1'b0;
      tx_start   <= 1'b0;
      rx_start   <= 1'b0;
      cmd_ch     <= '0;
      err        <= 1'b0;
      err_code   <= 3'd0;
    end else begin
      dac_wr   <= 1'b0;
      sat      <= 1'b0;
      tx_start <= 1'b0;
      rx_start <= 1'b0;
      err      <= 1'b0;
      err_code <= 3'd0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            word_q  <= cmd_data;
            state_q <= ST_DEC;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_DEC: begin
          pend_err_q <= err_d;
          pend_on_q  <= w_on;
          pend_off_q <= w_off;
          pend_dac_q <= w_inc || w_dec;
          pend_sat_q <= sat_d;
          pend_tx_q  <= w_snd;
          pend_rx_q  <= w_rcv;
          pend_ch_q  <= ch_d;
          pend_lvl_q <= lvl_d;
          state_q    <= ST_APPLY;
        end
        ST_APPLY: begin
          cmd_ch <= pend_ch_q;
          if (pend_err_q != 3'd0) begin
            err      <= 1'b1;
            err_code <= pend_err_q;
          end else begin
            if (pend_on_q) begin
              ch_en_q[pend_ch_q] <= 1'b1;
            end else if (pend_off_q) begin
              ch_en_q[pend_ch_q] <= 1'b0;
            end
            if (pend_dac_q) begin
              level_q[pend_ch_q] <= pend_lvl_q;
              dac_wr             <= 1'b1;
              dac_ch             <= pend_ch_q;
              dac_level          <= pend_lvl_q;
              sat                <= pend_sat_q;
            end
            tx_start <= pend_tx_q;
            rx_start <= pend_rx_q;
          end
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_decoder_mc.sv
// Self-checking bench for cmd_decoder_mc: directed scenarios plus random words
// compared against an integer-arithmetic reference model.
module tb_cmd_decoder_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  ch_en;
  logic        dac_wr;
  logic [0:0]  dac_ch;
  logic [7:0]  dac_level;
  logic        sat, tx_start, rx_start, err;
  logic [0:0]  cmd_ch;
  logic [2:0]  err_code;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_en [2];
  int m_lvl [2];
  int m_dac_ch, m_dac_level, m_cmd_ch;

  cmd_decoder_mc #(.DATA_WIDTH(16), .CH_W(1)) dut (
    .clk(clk), .rst(rst), .cmd_data(cmd_data), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .ch_en(ch_en), .dac_wr(dac_wr), .dac_ch(dac_ch),
    .dac_level(dac_level), .sat(sat), .tx_start(tx_start), .rx_start(rx_start),
    .cmd_ch(cmd_ch), .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_en[i]  = 0;
      m_lvl[i] = 0;
    end
    m_dac_ch = 0; m_dac_level = 0; m_cmd_ch = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_strobes"}, {27'd0, dac_wr, sat, tx_start, rx_start, err}, 32'd0);
    check_val({tag, "_ch_en"}, {30'd0, ch_en}, 32'd0);
    check_val({tag, "_dac_level"}, {24'd0, dac_level}, 32'd0);
    check_val({tag, "_chs"}, {30'd0, dac_ch, cmd_ch}, 32'd0);
    check_val({tag, "_err_code"}, {29'd0, err_code}, 32'd0);
  endtask

  // Applies the word's rules to the model and returns the expected strobes.
  task automatic model_word(input logic [15:0] w, output int e_err, output int e_code,
                            output int e_dac, output int e_sat, output int e_tx, output int e_rx);
    int on, off, inc, dec, rcv, snd, vld, ch, amt, en_after, t;
    on = w[0]; off = w[1]; inc = w[2]; dec = w[3];
    rcv = w[4]; snd = w[5]; vld = w[6]; ch = w[7]; amt = w[15:8];
    en_after = on ? 1 : (off ? 0 : m_en[ch]);
    e_code = 0;
    if (on && off) e_code = 1;
    else if (inc && dec) e_code = 2;
    else if (snd && rcv) e_code = 3;
    else if (!vld) e_code = 4;
    else if ((snd || rcv) && !en_after) e_code = 5;
    e_err = (e_code != 0);
    e_dac = 0; e_sat = 0; e_tx = 0; e_rx = 0;
    m_cmd_ch = ch;
    if (!e_err) begin
      m_en[ch] = en_after;
      if (inc || dec) begin
        t = inc ? m_lvl[ch] + amt : m_lvl[ch] - amt;
        if (t > 255) begin t = 255; e_sat = 1; end
        if (t < 0) begin t = 0; e_sat = 1; end
        m_lvl[ch] = t;
        e_dac = 1;
        m_dac_ch = ch;
        m_dac_level = t;
      end
      e_tx = snd;
      e_rx = rcv;
    end
  endtask

  task automatic send_word(input logic [15:0] w);
    int k, e_err, e_code, e_dac, e_sat, e_tx, e_rx;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    check_val("ready_before", {31'd0, cmd_ready}, 32'd1);
    cmd_data  = w;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_val("ready_n1", {31'd0, cmd_ready}, 32'd0);
    check_val("strobes_n1", {27'd0, dac_wr, sat, tx_start, rx_start, err}, 32'd0);
    @(posedge clk); #1;
    check_val("ready_n2", {31'd0, cmd_ready}, 32'd0);
    check_val("strobes_n2", {27'd0, dac_wr, sat, tx_start, rx_start, err}, 32'd0);
    model_word(w, e_err, e_code, e_dac, e_sat, e_tx, e_rx);
    @(posedge clk); #1;
    check_val("err", {31'd0, err}, e_err);
    check_val("err_code", {29'd0, err_code}, e_code);
    check_val("dac_wr", {31'd0, dac_wr}, e_dac);
    check_val("sat", {31'd0, sat}, e_sat);
    check_val("tx_rx", {30'd0, tx_start, rx_start}, (e_tx * 2) + e_rx);
    check_val("ch_en", {30'd0, ch_en}, (m_en[1] * 2) + m_en[0]);
    check_val("dac_ch", {31'd0, dac_ch}, m_dac_ch);
    check_val("dac_level", {24'd0, dac_level}, m_dac_level);
    check_val("cmd_ch", {31'd0, cmd_ch}, m_cmd_ch);
    check_val("ready_n3", {31'd0, cmd_ready}, 32'd1);
  endtask

  initial begin
    int acc;
    logic [15:0] w;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = 16'h0000;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b0;
    #1;
    check_val("ready_after_reset", {31'd0, cmd_ready}, 32'd1);

    // Directed scenarios
    send_word(16'h1045);
    send_word(16'hE044);
    send_word(16'h2044);
    send_word(16'hFF48);
    send_word(16'h0043);
    send_word(16'h00E0);
    send_word(16'h00E1);
    send_word(16'h0005);
    send_word(16'h0130);
    send_word(16'h0044);
    send_word(16'h0040);

    // Valid held high: one accept every third cycle
    @(negedge clk);
    cmd_data = 16'h0040; cmd_valid = 1'b1; acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_ready) acc++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    m_cmd_ch = 0;
    check_val("accepts_10cyc", acc, 32'd4);
    repeat (3) @(negedge clk);
    check_val("held_cmd_ch", {31'd0, cmd_ch}, m_cmd_ch);

    // Reset while the word sits in DEC
    @(negedge clk);
    cmd_data = 16'h1045; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    @(negedge clk); rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_all_zero("post_reset");
      check_val("post_reset_ready", {31'd0, cmd_ready}, 32'd1);
    end
    send_word(16'h1045);

    // Randomized words, biased toward accepted commands
    for (int i = 0; i < 300; i++) begin
      w = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) != 0) w[6] = 1'b1;
      if ($urandom_range(0, 1) != 0) w[1] = 1'b0;
      if ($urandom_range(0, 1) != 0) w[3] = 1'b0;
      if ($urandom_range(0, 1) != 0) w[4] = 1'b0;
      send_word(w);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
